btn_scan_ctrl: RTL and testbench



---
 rtl/btn_scan_pkg.sv | 20 ++
 rtl/btn_scan_ctrl_rr_pick.sv | 33 +++
 rtl/btn_scan_ctrl.sv | 142 ++++++++++++++
 tb/tb_btn_scan_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/btn_scan_pkg.sv
// Shared types and helpers for the button scan controller.
// Holds the FSM state encoding and a constant-foldable clog2.
package btn_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_EMIT   = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((32'sd1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/btn_scan_ctrl_rr_pick.sv
// Combinational round-robin arbiter: first set bit of cand at or after rr_ptr,
// wrapping modulo N.
module rr_pick
  import btn_scan_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = clog2(N)
) (
  input  logic [N-1:0]     cand,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  int pos_s;

  // Scan N slots starting at rr_ptr; the first candidate seen wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos_s = 0;
    for (int k = 0; k < N; k++) begin
      pos_s = (int'(rr_ptr) + k >= N) ? int'(rr_ptr) + k - N : int'(rr_ptr) + k;
      if (!found && cand[pos_s[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = pos_s[IDX_W-1:0];
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/btn_scan_ctrl.sv
// Debounces N buttons with one shared settle counter granted round-robin,
// and reports confirmed level changes on a valid/ready event port.
module btn_scan_ctrl
  import btn_scan_pkg::*;
#(
  parameter int N     = 4,
  parameter int LIMIT = 650000,
  parameter int CNT_W = 20,
  parameter int IDX_W = clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     btn_in,
  output logic [N-1:0]     btn_state,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [IDX_W-1:0] ev_idx,
  output logic             ev_press,
  output logic             busy
);

  if (LIMIT < 2 || (LIMIT - 1) >= (64'sd1 <<< CNT_W)) begin : g_cnt_w_check
    $error("btn_scan_ctrl: LIMIT-1 does not fit in CNT_W bits or LIMIT < 2");
  end

  logic [N-1:0]     sync1_r, sync_r;
  logic [N-1:0]     btn_state_r, btn_state_s;
  state_t           state_r, state_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic             lvl_r, lvl_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [IDX_W-1:0] rr_ptr_r, rr_ptr_s;
  logic             ev_valid_r, ev_valid_s;
  logic [IDX_W-1:0] ev_idx_r, ev_idx_s;
  logic             ev_press_r, ev_press_s;
  logic             busy_r;
  logic [N-1:0]     cand_s;
  logic             pick_found_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic [IDX_W-1:0] idx_inc_s;

  // Buttons whose synchronized level disagrees with the debounced level.
  assign cand_s    = sync_r ^ btn_state_r;
  assign idx_inc_s = (idx_r == IDX_W'(N - 1)) ? IDX_W'(0) : idx_r + IDX_W'(1);

  rr_pick #(.N(N), .IDX_W(IDX_W)) u_rr_pick (
    .cand   (cand_s),
    .rr_ptr (rr_ptr_r),
    .found  (pick_found_s),
    .idx    (pick_idx_s)
  );

  // Next-state and output decode for the grant / settle / emit sequence.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    lvl_s       = lvl_r;
    cnt_s       = cnt_r;
    rr_ptr_s    = rr_ptr_r;
    btn_state_s = btn_state_r;
    ev_valid_s  = ev_valid_r;
    ev_idx_s    = ev_idx_r;
    ev_press_s  = ev_press_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_found_s) begin
          idx_s   = pick_idx_s;
          lvl_s   = sync_r[pick_idx_s];
          cnt_s   = '0;
          state_s = ST_SETTLE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (sync_r[idx_r] != lvl_r) begin
          // A bounce on the granted button forfeits its turn.
          rr_ptr_s = idx_inc_s;
          state_s  = ST_IDLE;
        end else if (cnt_r == CNT_W'(LIMIT - 1)) begin
          btn_state_s[idx_r] = lvl_r;
          ev_idx_s           = idx_r;
          ev_press_s         = lvl_r;
          ev_valid_s         = 1'b1;
          state_s            = ST_EMIT;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_EMIT: begin
        if (ev_ready) begin
          ev_valid_s = 1'b0;
          rr_ptr_s   = idx_inc_s;
          state_s    = ST_IDLE;
        end else begin
          state_s = ST_EMIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, synchronizer and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r     <= '0;
      sync_r      <= '0;
      state_r     <= ST_IDLE;
      idx_r       <= '0;
      lvl_r       <= 1'b0;
      cnt_r       <= '0;
      rr_ptr_r    <= '0;
      btn_state_r <= '0;
      ev_valid_r  <= 1'b0;
      ev_idx_r    <= '0;
      ev_press_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      sync1_r     <= btn_in;
      sync_r      <= sync1_r;
      state_r     <= state_s;
      idx_r       <= idx_s;
      lvl_r       <= lvl_s;
      cnt_r       <= cnt_s;
      rr_ptr_r    <= rr_ptr_s;
      btn_state_r <= btn_state_s;
      ev_valid_r  <= ev_valid_s;
      ev_idx_r    <= ev_idx_s;
      ev_press_r  <= ev_press_s;
      busy_r      <= (state_s != ST_IDLE);
    end
  end

  assign btn_state = btn_state_r;
  assign ev_valid  = ev_valid_r;
  assign ev_idx    = ev_idx_r;
  assign ev_press  = ev_press_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_btn_scan_ctrl.sv
// Self-checking bench for btn_scan_ctrl (N=4, LIMIT=8): phase table, directed
// reset/latency sequences and random stimulus against a timestamp-based model.
module tb_btn_scan_ctrl;

  localparam int N     = 4;
  localparam int LIMIT = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn_in;
  logic [3:0] btn_state;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_idx;
  logic       ev_press;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  btn_scan_ctrl #(.N(N), .LIMIT(LIMIT), .CNT_W(4), .IDX_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_in    (btn_in),
    .btn_state (btn_state),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_idx    (ev_idx),
    .ev_press  (ev_press),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a grant is remembered with the cycle it happened in;
  // the event fires once LIMIT later cycles all saw the granted level.
  int         m_cyc   = 0;
  logic [3:0] m_q1    = '0;
  logic [3:0] m_s     = '0;
  logic [3:0] m_btn   = '0;
  int         g_idx   = -1;
  int         g_t     = 0;
  logic       m_lvl   = 1'b0;
  bit         m_emit  = 1'b0;
  int         m_eidx  = 0;
  bit         m_epress = 1'b0;
  int         m_ptr   = 0;

  // Per-phase event log
  int          ph_events;
  logic [31:0] ph_seq;
  bit          ph_last_press;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_edge();
    logic [3:0] cand;
    m_cyc++;
    if (!rst_n) begin
      m_q1 = '0; m_s = '0; m_btn = '0; g_idx = -1;
      m_emit = 1'b0; m_eidx = 0; m_epress = 1'b0; m_ptr = 0;
    end else begin
      cand = m_s ^ m_btn;
      if (m_emit) begin
        if (ev_ready) begin
          m_emit = 1'b0;
          m_ptr  = (m_eidx + 1) % N;
        end
      end else if (g_idx >= 0) begin
        if (m_s[g_idx] != m_lvl) begin
          m_ptr = (g_idx + 1) % N;
          g_idx = -1;
        end else if (m_cyc - g_t == LIMIT) begin
          m_btn[g_idx] = m_lvl;
          m_eidx   = g_idx;
          m_epress = m_lvl;
          m_emit   = 1'b1;
          g_idx    = -1;
        end
      end else if (cand != 4'b0000) begin
        for (int k = 0; k < N; k++) begin
          if (g_idx < 0 && cand[(m_ptr + k) % N]) g_idx = (m_ptr + k) % N;
        end
        m_lvl = m_s[g_idx];
        g_t   = m_cyc;
      end
      m_s  = m_q1;
      m_q1 = btn_in;
    end
  endtask

  task automatic step();
    bit         hs;
    logic [1:0] pidx;
    logic       ppress;
    hs     = rst_n && (ev_valid === 1'b1) && ev_ready;
    pidx   = ev_idx;
    ppress = ev_press;
    model_edge();
    @(posedge clk);
    #1;
    if (hs) begin
      ph_events++;
      ph_seq        = (ph_seq << 4) | {30'd0, pidx} + 32'd1;
      ph_last_press = ppress;
    end
    chk("btn_state", {28'd0, btn_state}, {28'd0, m_btn});
    chk("ev_valid", {31'd0, ev_valid}, {31'd0, m_emit});
    chk("busy", {31'd0, busy}, (g_idx >= 0 || m_emit) ? 32'd1 : 32'd0);
    chk("ev_idx", {30'd0, ev_idx}, m_eidx);
    chk("ev_press", {31'd0, ev_press}, {31'd0, m_epress});
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    for (int i = 1; i <= 50; i++) begin
      step();
      if (ev_valid === 1'b1) begin
        n = i;
        break;
      end
    end
    if (n == 0) n = 99;
  endtask

  typedef struct {
    bit          rst;
    logic [3:0]  btn;
    bit          rdy;
    int          cycles;
    logic [3:0]  exp_state;
    int          exp_events;
    logic [31:0] exp_seq;
    bit          exp_last_press;
  } phase_t;

  phase_t tbl[11];

  initial begin
    int lat;
    tbl[0]  = '{1'b1, 4'b0000, 1'b1,  2, 4'b0000, 0, 32'h0,    1'b0};
    tbl[1]  = '{1'b0, 4'b1111, 1'b1, 60, 4'b1111, 4, 32'h1234, 1'b1};
    tbl[2]  = '{1'b0, 4'b0000, 1'b1, 60, 4'b0000, 4, 32'h1234, 1'b0};
    tbl[3]  = '{1'b0, 4'b0001, 1'b1, 20, 4'b0001, 1, 32'h1,    1'b1};
    tbl[4]  = '{1'b0, 4'b0101, 1'b1,  5, 4'b0001, 0, 32'h0,    1'b0};
    tbl[5]  = '{1'b0, 4'b0001, 1'b1, 12, 4'b0001, 0, 32'h0,    1'b0};
    tbl[6]  = '{1'b0, 4'b0101, 1'b1, 20, 4'b0101, 1, 32'h3,    1'b1};
    tbl[7]  = '{1'b0, 4'b0111, 1'b0, 30, 4'b0111, 0, 32'h0,    1'b0};
    tbl[8]  = '{1'b0, 4'b1111, 1'b0, 30, 4'b0111, 0, 32'h0,    1'b0};
    tbl[9]  = '{1'b0, 4'b1111, 1'b1, 30, 4'b1111, 2, 32'h24,   1'b1};
    tbl[10] = '{1'b0, 4'b1101, 1'b1, 20, 4'b1101, 1, 32'h2,    1'b0};

    rst_n = 1'b0; btn_in = 4'b0000; ev_ready = 1'b0;

    for (int p = 0; p < 11; p++) begin
      rst_n = !tbl[p].rst; btn_in = tbl[p].btn; ev_ready = tbl[p].rdy;
      ph_events = 0; ph_seq = 32'h0; ph_last_press = 1'b0;
      repeat (tbl[p].cycles) step();
      chk($sformatf("phase%0d_state", p), {28'd0, btn_state}, {28'd0, tbl[p].exp_state});
      chk($sformatf("phase%0d_events", p), ph_events, tbl[p].exp_events);
      chk($sformatf("phase%0d_order", p), ph_seq, tbl[p].exp_seq);
      if (tbl[p].exp_events > 0)
        chk($sformatf("phase%0d_press", p), {31'd0, ph_last_press}, {31'd0, tbl[p].exp_last_press});
    end

    // Reset during SETTLE, then during EMIT, with button 1 held throughout.
    rst_n = 1'b0; btn_in = 4'b0000; ev_ready = 1'b0;
    step(); step();
    rst_n = 1'b1; btn_in = 4'b0010;
    repeat (6) step();
    chk("settle_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    step();
    chk("rst_settle_out", {25'd0, btn_state, ev_valid, ev_idx, ev_press, busy}, 32'd0);
    rst_n = 1'b1;
    wait_valid(lat);
    chk("latency_after_rst", lat, 11);
    chk("ev_idx_after_rst", {30'd0, ev_idx}, 32'd1);
    chk("ev_press_after_rst", {31'd0, ev_press}, 32'd1);
    repeat (3) step();
    rst_n = 1'b0;
    step();
    chk("rst_emit_out", {25'd0, btn_state, ev_valid, ev_idx, ev_press, busy}, 32'd0);
    rst_n = 1'b1; ev_ready = 1'b1;
    wait_valid(lat);
    chk("latency_fresh", lat, 11);
    chk("ev_idx_fresh", {30'd0, ev_idx}, 32'd1);
    step();
    chk("valid_drop", {31'd0, ev_valid}, 32'd0);

    // Random button activity and back-pressure, checked cycle by cycle.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0) btn_in = 4'($urandom);
      ev_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
